// File: rtl/deser_pkg.sv
// Shared types and constants for the 1-to-4 deserializer with word alignment.
package deser_pkg;

  // Width of the consecutive-match counter (LOCK_CNT tops out at 15).
  localparam int MC_W   = 4;

  // Width of an assembled parallel word.
  localparam int WORD_W = 4;

  // Alignment state machine states.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/deser_shift4.sv
// Serial-to-parallel datapath: shift register, bit counter, bit-slip gating
// and the registered Q/QV outputs. The completed word is also offered
// combinationally so the alignment FSM can judge it on the same edge that
// loads Q, which keeps LOCK aligned with the QV of the deciding word.
module deser_shift4
  import deser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              d_i,
  input  logic              dv_i,
  input  logic              slip_set_i,
  input  logic              slip_clr_i,
  output logic [WORD_W-1:0] word_o,
  output logic              done_o,
  output logic              drop_o,
  output logic [WORD_W-1:0] q_o,
  output logic              qv_o
);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [1:0]        cnt_q;
  logic              slip_q;
  logic [WORD_W-1:0] q_q;
  logic              qv_q;
  logic              accept;

  // Decide whether this cycle's bit is shifted in or discarded by a slip,
  // and form the register contents that would result from shifting it.
  always_comb begin
    accept = dv_i & ~slip_q;
    drop_o = dv_i & slip_q;
    if (MSB_FIRST) begin
      sr_d = {sr_q[WORD_W-2:0], d_i};
    end else begin
      sr_d = {d_i, sr_q[WORD_W-1:1]};
    end
    done_o = accept & (cnt_q == 2'd3);
    word_o = sr_d;
  end

  // Shift/count on accepted bits, publish finished words, track pending slip.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_q   <= '0;
      cnt_q  <= 2'd0;
      slip_q <= 1'b0;
      q_q    <= '0;
      qv_q   <= 1'b0;
    end else begin
      qv_q <= done_o;
      if (done_o) begin
        q_q <= sr_d;
      end
      if (accept) begin
        sr_q  <= sr_d;
        cnt_q <= cnt_q + 2'd1;
      end
      // A resync cancels any slip; a new request arms it; a discarded bit consumes it.
      if (slip_clr_i) begin
        slip_q <= 1'b0;
      end else if (slip_set_i) begin
        slip_q <= 1'b1;
      end else if (drop_o) begin
        slip_q <= 1'b0;
      end
    end
  end

  assign q_o  = q_q;
  assign qv_o = qv_q;

endmodule

// File: rtl/deser1x4_align.sv
// 1-to-4 deserializer with automatic word alignment. The datapath lives in
// deser_shift4; this level hunts for ALIGN_PAT, slipping one bit after every
// mismatching word, and declares LOCK after LOCK_CNT consecutive matches.
//
// Handshake: DV qualifies D; a bit is consumed on a rising CLK edge only when
// DV=1 (and is discarded instead when a slip is pending). QV is a one-cycle
// pulse on the cycle Q carries a freshly completed word; there is no
// back-pressure, the receiver must take Q while QV=1.
module deser1x4_align
  import deser_pkg::*;
#(
  parameter logic [3:0] ALIGN_PAT = 4'b1100,
  parameter int         LOCK_CNT  = 3,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       D,
  input  logic       DV,
  input  logic       RESYNC,
  output logic [3:0] Q,
  output logic       QV,
  output logic       LOCK,
  output logic [1:0] PHASE,
  output logic [1:0] DBG_STATE
);

  localparam logic [MC_W-1:0] LOCK_CNT_L = MC_W'(LOCK_CNT);

  state_e            state_q;
  logic [MC_W-1:0]   mc_q;
  logic [MC_W-1:0]   mc_inc;
  logic              lock_q;
  logic [1:0]        phase_q;
  logic [WORD_W-1:0] word;
  logic              done;
  logic              drop;
  logic              match;
  logic              slip_set;

  deser_shift4 #(
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk_i      (CLK),
    .rst_n_i    (RSTN),
    .d_i        (D),
    .dv_i       (DV),
    .slip_set_i (slip_set),
    .slip_clr_i (RESYNC),
    .word_o     (word),
    .done_o     (done),
    .drop_o     (drop),
    .q_o        (Q),
    .qv_o       (QV)
  );

  // Judge the word completing this cycle; a mismatch while still aligning
  // requests a slip unless RESYNC is overriding the state machine.
  always_comb begin
    match    = (word == ALIGN_PAT);
    mc_inc   = mc_q + 1'b1;
    slip_set = done & ~RESYNC & ~match & (state_q != LOCKED);
  end

  // Alignment state machine with match counter, LOCK and slip phase.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= HUNT;
      mc_q    <= '0;
      lock_q  <= 1'b0;
      phase_q <= 2'd0;
    end else begin
      if (drop) begin
        phase_q <= phase_q + 2'd1;
      end
      if (RESYNC) begin
        // RESYNC beats any word completing this cycle; that word is not counted.
        state_q <= HUNT;
        mc_q    <= '0;
        lock_q  <= 1'b0;
      end else if (done) begin
        case (state_q)
          HUNT: begin
            if (match) begin
              mc_q <= {{(MC_W-1){1'b0}}, 1'b1};
              if (LOCK_CNT_L == {{(MC_W-1){1'b0}}, 1'b1}) begin
                state_q <= LOCKED;
                lock_q  <= 1'b1;
              end else begin
                state_q <= CHECK;
              end
            end
          end
          CHECK: begin
            if (match) begin
              mc_q <= mc_inc;
              if (mc_inc == LOCK_CNT_L) begin
                state_q <= LOCKED;
                lock_q  <= 1'b1;
              end
            end else begin
              mc_q    <= '0;
              state_q <= HUNT;
            end
          end
          LOCKED: begin
            // Words pass unchecked once aligned.
          end
          default: begin
            state_q <= HUNT;
            mc_q    <= '0;
            lock_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign LOCK      = lock_q;
  assign PHASE     = phase_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_deser1x4_align.sv
// Bench for deser1x4_align: per-cycle vector table for the MSB-first,
// LOCK_CNT=3 instance, expected words queued for QV checking, and a
// hand-written gapped-DV sequence for an LSB-first, LOCK_CNT=1 instance.
module tb_deser1x4_align;
  import deser_pkg::*;

  typedef struct {
    logic       dv;
    logic       d;
    logic       rs;
    logic       push;
    logic [3:0] pw;
    logic       lk;
    logic [1:0] ph;
    state_e     st;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  logic [3:0] exp2_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // main DUT: defaults (ALIGN_PAT=1100, LOCK_CNT=3, MSB_FIRST=1)
  logic       d, dv, rs;
  logic [3:0] q;
  logic       qv, lock;
  logic [1:0] phase, dbg_state;

  // second DUT: LSB first, LOCK_CNT=1
  logic       d2, dv2, rs2;
  logic [3:0] q2;
  logic       qv2, lock2;
  logic [1:0] phase2, dbg_state2;

  deser1x4_align dut (
    .CLK       (clk),
    .RSTN      (rstn),
    .D         (d),
    .DV        (dv),
    .RESYNC    (rs),
    .Q         (q),
    .QV        (qv),
    .LOCK      (lock),
    .PHASE     (phase),
    .DBG_STATE (dbg_state)
  );

  deser1x4_align #(
    .ALIGN_PAT (4'b1100),
    .LOCK_CNT  (1),
    .MSB_FIRST (1'b0)
  ) dut_lsb (
    .CLK       (clk),
    .RSTN      (rstn),
    .D         (d2),
    .DV        (dv2),
    .RESYNC    (rs2),
    .Q         (q2),
    .QV        (qv2),
    .LOCK      (lock2),
    .PHASE     (phase2),
    .DBG_STATE (dbg_state2)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: QV must be low while nothing is expected; each QV pops a word.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (exp_q.size() == 0) check("qv_idle", 32'(qv), 32'd0);
      else if (qv === 1'b1) check("q_word", 32'(q), 32'(exp_q.pop_front()));
      if (exp2_q.size() == 0) check("qv2_idle", 32'(qv2), 32'd0);
      else if (qv2 === 1'b1) check("q2_word", 32'(q2), 32'(exp2_q.pop_front()));
    end
  end

  // ---------------- vector table builders ----------------
  task automatic add_bit(input logic v_dv, input logic v_d, input logic v_lk,
                         input logic [1:0] v_ph, input state_e v_st);
    vec_t v;
    v.dv = v_dv; v.d = v_d; v.rs = 1'b0; v.push = 1'b0; v.pw = 4'h0;
    v.lk = v_lk; v.ph = v_ph; v.st = v_st;
    vecs.push_back(v);
  endtask

  // Four consecutive DV=1 bits, first bit = w[3]; state/lock change on the last.
  task automatic add_word(input logic [3:0] w, input logic rs_last,
                          input logic lk0, input logic lk1, input logic [1:0] v_ph,
                          input state_e s0, input state_e s1);
    vec_t v;
    for (int i = 3; i >= 0; i--) begin
      v.dv   = 1'b1;
      v.d    = w[i];
      v.rs   = (i == 0) ? rs_last : 1'b0;
      v.push = (i == 0);
      v.pw   = w;
      v.lk   = (i == 0) ? lk1 : lk0;
      v.ph   = v_ph;
      v.st   = (i == 0) ? s1 : s0;
      vecs.push_back(v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      d  = vecs[i].d;
      dv = vecs[i].dv;
      rs = vecs[i].rs;
      if (vecs[i].push) exp_q.push_back(vecs[i].pw);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_lock[%0d]", tag, i), 32'(lock), 32'(vecs[i].lk));
      check($sformatf("%s_phase[%0d]", tag, i), 32'(phase), 32'(vecs[i].ph));
      check($sformatf("%s_state[%0d]", tag, i), 32'(dbg_state), 32'(vecs[i].st));
    end
    d = 1'b0; dv = 1'b0; rs = 1'b0;
    vecs.delete();
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s_drained", tag), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Two stray bits, then reset asserted between edges; outputs must clear at once.
  task automatic reset_mid(input string tag);
    dv = 1'b1; d = 1'b1;
    @(posedge clk); @(negedge clk);
    d = 1'b0;
    @(posedge clk); @(negedge clk);
    dv = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check($sformatf("%s_rst_q", tag), 32'(q), 32'd0);
    check($sformatf("%s_rst_qv", tag), 32'(qv), 32'd0);
    check($sformatf("%s_rst_lock", tag), 32'(lock), 32'd0);
    check($sformatf("%s_rst_phase", tag), 32'(phase), 32'd0);
    check($sformatf("%s_rst_state", tag), 32'(dbg_state), 32'(HUNT));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- test ----------------
  initial begin
    rstn = 1'b0;
    d = 1'b0; dv = 1'b0; rs = 1'b0;
    d2 = 1'b0; dv2 = 1'b0; rs2 = 1'b0;
    #12;
    check("por_q", 32'(q), 32'd0);
    check("por_qv", 32'(qv), 32'd0);
    check("por_lock", 32'(lock), 32'd0);
    check("por_phase", 32'(phase), 32'd0);
    check("por_q2", 32'(q2), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Idle with DV=0 and random D: nothing may change.
    for (int i = 0; i < 10; i++) begin
      d  = 1'($urandom_range(0, 1));
      d2 = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      check($sformatf("idle_q[%0d]", i), 32'(q), 32'd0);
      check($sformatf("idle_lock[%0d]", i), 32'(lock), 32'd0);
      check($sformatf("idle_phase[%0d]", i), 32'(phase), 32'd0);
      check($sformatf("idle_lock2[%0d]", i), 32'(lock2), 32'd0);
    end
    d = 1'b0; d2 = 1'b0;

    // Aligned stream: lock on the third word, no slip.
    add_word(4'b1100, 1'b0, 1'b0, 1'b0, 2'd0, HUNT,  CHECK);
    add_word(4'b1100, 1'b0, 1'b0, 1'b0, 2'd0, CHECK, CHECK);
    add_word(4'b1100, 1'b0, 1'b0, 1'b1, 2'd0, CHECK, LOCKED);
    apply_vecs("aligned");
    reset_mid("r1");

    // One-bit offset: first word 0110, next bit dropped, then lock.
    add_word(4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, HUNT, HUNT);
    add_bit(1'b1, 1'b0, 1'b0, 2'd1, HUNT);
    add_word(4'b1100, 1'b0, 1'b0, 1'b0, 2'd1, HUNT,  CHECK);
    add_word(4'b1100, 1'b0, 1'b0, 1'b0, 2'd1, CHECK, CHECK);
    add_word(4'b1100, 1'b0, 1'b0, 1'b1, 2'd1, CHECK, LOCKED);
    apply_vecs("offset");
    reset_mid("r2");

    // Mismatch in CHECK with DV gaps, slip, relock, then RESYNC cases.
    add_word(4'b1100, 1'b0, 1'b0, 1'b0, 2'd0, HUNT, CHECK);
    add_bit(1'b0, 1'b1, 1'b0, 2'd0, CHECK);
    add_word(4'b1100, 1'b0, 1'b0, 1'b0, 2'd0, CHECK, CHECK);
    add_word(4'b1010, 1'b0, 1'b0, 1'b0, 2'd0, CHECK, HUNT);
    add_bit(1'b0, 1'b0, 1'b0, 2'd0, HUNT);
    add_bit(1'b1, 1'b1, 1'b0, 2'd1, HUNT);
    add_word(4'b1100, 1'b0, 1'b0, 1'b0, 2'd1, HUNT,  CHECK);
    add_word(4'b1100, 1'b0, 1'b0, 1'b0, 2'd1, CHECK, CHECK);
    add_word(4'b1100, 1'b0, 1'b0, 1'b1, 2'd1, CHECK, LOCKED);
    // RESYNC with a matching word while LOCKED: word still output, not counted.
    add_word(4'b1100, 1'b1, 1'b1, 1'b0, 2'd1, LOCKED, HUNT);
    add_word(4'b1100, 1'b0, 1'b0, 1'b0, 2'd1, HUNT,  CHECK);
    add_word(4'b1100, 1'b0, 1'b0, 1'b0, 2'd1, CHECK, CHECK);
    add_word(4'b1100, 1'b0, 1'b0, 1'b1, 2'd1, CHECK, LOCKED);
    // RESYNC with a mismatching word: no slip requested, next word stays aligned.
    add_word(4'b0101, 1'b1, 1'b1, 1'b0, 2'd1, LOCKED, HUNT);
    add_word(4'b1100, 1'b0, 1'b0, 1'b0, 2'd1, HUNT,  CHECK);
    apply_vecs("check_resync");
    reset_mid("r3");

    // LSB-first, LOCK_CNT=1, gapped DV: bits 0,0,1,1 -> Q=1100, LOCK with QV.
    begin
      logic [6:0] dv_seq;
      logic [6:0] d_seq;
      dv_seq = 7'b1010101;
      d_seq  = 7'b0100101;
      for (int i = 0; i < 7; i++) begin
        dv2 = dv_seq[6-i];
        d2  = d_seq[6-i];
        if (i == 6) exp2_q.push_back(4'b1100);
        @(posedge clk); @(negedge clk);
        check($sformatf("lsb_lock[%0d]", i), 32'(lock2), (i == 6) ? 32'd1 : 32'd0);
        check($sformatf("lsb_state[%0d]", i), 32'(dbg_state2),
              (i == 6) ? 32'(LOCKED) : 32'(HUNT));
      end
      dv2 = 1'b0; d2 = 1'b0;
      @(posedge clk); @(negedge clk);
      check("lsb_phase", 32'(phase2), 32'd0);
      check("lsb_q_hold", 32'(q2), 32'hC);
      check("lsb_drained", 32'(exp2_q.size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
